// File: rtl/normalize_round_pipe.sv
// normalize_round_pipe
//   Two-stage normalize-and-round pipeline. Converts an unnormalized
//   sign/exponent/magnitude value into a rounded float with a hidden bit,
//   FRAC_WIDTH fraction bits and a signed unbiased exponent.
//   S1 registers the input together with its leading-zero count.
//   S2 left-shifts by that count, rounds to nearest even, clamps the exponent
//   range and drives the out* ports.
// Ports
//   clock, resetn               rising-edge clock, asynchronous active-low reset
//   inValid/inReady             input handshake (inReady is combinational from outReady)
//   inSign, inExp, inMag        value = (inMag / 2^(IN_WIDTH-1)) * 2^inExp
//   outValid/outReady           output handshake
//   outSign, outExp, outFrac    rounded result
//   outZero, outOverflow,
//   outUnderflow, outInexact    result classification flags
module normalize_round_pipe #(
  parameter int IN_WIDTH   = 16,
  parameter int FRAC_WIDTH = 7,
  parameter int EXP_WIDTH  = 10,
  parameter int EXP_MAX    = 127,
  parameter int EXP_MIN    = -126
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic                        inSign,
  input  logic signed [EXP_WIDTH-1:0] inExp,
  input  logic [IN_WIDTH-1:0]         inMag,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        outSign,
  output logic signed [EXP_WIDTH-1:0] outExp,
  output logic [FRAC_WIDTH-1:0]       outFrac,
  output logic                        outZero,
  output logic                        outOverflow,
  output logic                        outUnderflow,
  output logic                        outInexact
);

  localparam int LZC_W = $clog2(IN_WIDTH + 1);
  localparam int EW2   = EXP_WIDTH + 2;
  // Number of shifted bits below the fraction field, excluding the guard bit.
  localparam int LOW_W = IN_WIDTH - 2 - FRAC_WIDTH;
  localparam logic signed [EW2-1:0] E_MAX = EW2'(EXP_MAX);
  localparam logic signed [EW2-1:0] E_MIN = EW2'(EXP_MIN);

  // Handshake
  logic s1_adv, s2_adv;

  // Stage 1 registers
  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_sign_q,  s1_sign_d;
  logic signed [EXP_WIDTH-1:0] s1_exp_q,   s1_exp_d;
  logic [IN_WIDTH-1:0]         s1_mag_q,   s1_mag_d;
  logic [LZC_W-1:0]            s1_lzc_q,   s1_lzc_d;
  logic                        s1_zero_q,  s1_zero_d;

  // Stage 2 registers
  logic                        s2_valid_q,   s2_valid_d;
  logic                        s2_sign_q,    s2_sign_d;
  logic signed [EXP_WIDTH-1:0] s2_exp_q,     s2_exp_d;
  logic [FRAC_WIDTH-1:0]       s2_frac_q,    s2_frac_d;
  logic                        s2_zero_q,    s2_zero_d;
  logic                        s2_ovf_q,     s2_ovf_d;
  logic                        s2_unf_q,     s2_unf_d;
  logic                        s2_inexact_q, s2_inexact_d;

  // Stage 2 datapath
  logic [LZC_W-1:0]      lzc;
  logic [IN_WIDTH-1:0]   sh;
  logic [FRAC_WIDTH-1:0] f, f_rnd;
  logic                  g, sticky, round_up, carry, is_zero;
  logic [EW2-1:0]        exp_ext;
  logic signed [EW2-1:0] e_sum;

  assign s2_adv  = !s2_valid_q || outReady;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign inReady = s1_adv;

  // Leading-zero count: scanning upward, the last set bit seen is the MSB.
  always_comb begin
    lzc = LZC_W'(IN_WIDTH);
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (inMag[i]) lzc = LZC_W'(IN_WIDTH - 1 - i);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mag_d   = s1_mag_q;
    s1_lzc_d   = s1_lzc_q;
    s1_zero_d  = s1_zero_q;
    if (s1_adv) begin
      s1_valid_d = inValid;
      if (inValid) begin
        s1_sign_d = inSign;
        s1_exp_d  = inExp;
        s1_mag_d  = inMag;
        s1_lzc_d  = lzc;
        s1_zero_d = (inMag == '0);
      end
    end
  end

  always_comb begin
    sh     = s1_mag_q << s1_lzc_q;
    f      = sh[IN_WIDTH-2 -: FRAC_WIDTH];
    g      = sh[LOW_W];
    sticky = 1'b0;
    for (int unsigned i = 0; i < LOW_W; i++) begin
      sticky = sticky | sh[i];
    end
    round_up = g & (sticky | f[0]);
    carry    = round_up & (&f);
    f_rnd    = f + FRAC_WIDTH'(round_up);
    exp_ext  = {{2{s1_exp_q[EXP_WIDTH-1]}}, s1_exp_q};
    e_sum    = exp_ext - EW2'(s1_lzc_q) + EW2'(carry);
    // After normalization the hidden bit is clear only for a zero magnitude.
    is_zero  = s1_zero_q | ~sh[IN_WIDTH-1];
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_sign_d    = s2_sign_q;
    s2_exp_d     = s2_exp_q;
    s2_frac_d    = s2_frac_q;
    s2_zero_d    = s2_zero_q;
    s2_ovf_d     = s2_ovf_q;
    s2_unf_d     = s2_unf_q;
    s2_inexact_d = s2_inexact_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d    = s1_sign_q;
        s2_zero_d    = 1'b0;
        s2_ovf_d     = 1'b0;
        s2_unf_d     = 1'b0;
        s2_exp_d     = '0;
        s2_frac_d    = '0;
        s2_inexact_d = 1'b0;
        if (is_zero) begin
          s2_zero_d = 1'b1;
        end else if (e_sum > E_MAX) begin
          s2_ovf_d     = 1'b1;
          s2_exp_d     = EXP_WIDTH'(EXP_MAX);
          s2_frac_d    = '1;
          s2_inexact_d = 1'b1;
        end else if (e_sum < E_MIN) begin
          s2_unf_d     = 1'b1;
          s2_zero_d    = 1'b1;
          s2_inexact_d = 1'b1;
        end else begin
          s2_exp_d     = e_sum[EXP_WIDTH-1:0];
          s2_frac_d    = f_rnd;
          s2_inexact_d = g | sticky;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mag_q     <= '0;
      s1_lzc_q     <= '0;
      s1_zero_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_frac_q    <= '0;
      s2_zero_q    <= 1'b0;
      s2_ovf_q     <= 1'b0;
      s2_unf_q     <= 1'b0;
      s2_inexact_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_mag_q     <= s1_mag_d;
      s1_lzc_q     <= s1_lzc_d;
      s1_zero_q    <= s1_zero_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_exp_q     <= s2_exp_d;
      s2_frac_q    <= s2_frac_d;
      s2_zero_q    <= s2_zero_d;
      s2_ovf_q     <= s2_ovf_d;
      s2_unf_q     <= s2_unf_d;
      s2_inexact_q <= s2_inexact_d;
    end
  end

  assign outValid     = s2_valid_q;
  assign outSign      = s2_sign_q;
  assign outExp       = s2_exp_q;
  assign outFrac      = s2_frac_q;
  assign outZero      = s2_zero_q;
  assign outOverflow  = s2_ovf_q;
  assign outUnderflow = s2_unf_q;
  assign outInexact   = s2_inexact_q;

endmodule
